// File: rtl/register_bank.sv
// register_bank: 32 x N general-purpose register storage, one synchronous write port, r0 hardwired to zero.
// Optional REGISTER_BANK_WRITE_BYPASS_EN forwards WriteData onto the addressed Data_k within the write cycle.
module register_bank #(
  parameter int          N        = 32,
  parameter logic [31:0] GP_RESET = 32'h1000_8000,
  parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RegWrite,
  input  logic [4:0]   WriteRegister,
  input  logic [N-1:0] WriteData,
  output logic [N-1:0] Data_0,
  output logic [N-1:0] Data_1,
  output logic [N-1:0] Data_2,
  output logic [N-1:0] Data_3,
  output logic [N-1:0] Data_4,
  output logic [N-1:0] Data_5,
  output logic [N-1:0] Data_6,
  output logic [N-1:0] Data_7,
  output logic [N-1:0] Data_8,
  output logic [N-1:0] Data_9,
  output logic [N-1:0] Data_10,
  output logic [N-1:0] Data_11,
  output logic [N-1:0] Data_12,
  output logic [N-1:0] Data_13,
  output logic [N-1:0] Data_14,
  output logic [N-1:0] Data_15,
  output logic [N-1:0] Data_16,
  output logic [N-1:0] Data_17,
  output logic [N-1:0] Data_18,
  output logic [N-1:0] Data_19,
  output logic [N-1:0] Data_20,
  output logic [N-1:0] Data_21,
  output logic [N-1:0] Data_22,
  output logic [N-1:0] Data_23,
  output logic [N-1:0] Data_24,
  output logic [N-1:0] Data_25,
  output logic [N-1:0] Data_26,
  output logic [N-1:0] Data_27,
  output logic [N-1:0] Data_28,
  output logic [N-1:0] Data_29,
  output logic [N-1:0] Data_30,
  output logic [N-1:0] Data_31
);

  localparam logic [N-1:0] GP_INIT = N'(GP_RESET);
  localparam logic [N-1:0] SP_INIT = N'(SP_RESET);

  logic [N-1:0] regs [1:31];
  logic [31:1]  we;
  logic [N-1:0] view [0:31];

  // One-hot write-enable decode; index 0 has no enable, so writes to r0 vanish.
  always_comb begin
    we = '0;
    if (RegWrite) begin
      for (int k = 1; k < 32; k++) begin
        we[k] = (WriteRegister == k[4:0]);
      end
    end else begin
      we = '0;
    end
  end

  // Register storage with asynchronous reset to the ABI start values.
  always_ff @(posedge clk or posedge reset) begin
    for (int k = 1; k < 32; k++) begin
      if (reset) begin
        if (k == 28) begin
          regs[k] <= GP_INIT;
        end else if (k == 29) begin
          regs[k] <= SP_INIT;
        end else begin
          regs[k] <= '0;
        end
      end else if (we[k]) begin
        regs[k] <= WriteData;
      end else begin
        regs[k] <= regs[k];
      end
    end
  end

  // Output view; during reset regs already hold reset values, so bypass is suppressed.
  always_comb begin
    view[0] = '0;
    for (int k = 1; k < 32; k++) begin
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
      if (!reset && we[k]) begin
        view[k] = WriteData;
      end else begin
        view[k] = regs[k];
      end
`else
      view[k] = regs[k];
`endif
    end
  end

  assign Data_0  = view[0];
  assign Data_1  = view[1];
  assign Data_2  = view[2];
  assign Data_3  = view[3];
  assign Data_4  = view[4];
  assign Data_5  = view[5];
  assign Data_6  = view[6];
  assign Data_7  = view[7];
  assign Data_8  = view[8];
  assign Data_9  = view[9];
  assign Data_10 = view[10];
  assign Data_11 = view[11];
  assign Data_12 = view[12];
  assign Data_13 = view[13];
  assign Data_14 = view[14];
  assign Data_15 = view[15];
  assign Data_16 = view[16];
  assign Data_17 = view[17];
  assign Data_18 = view[18];
  assign Data_19 = view[19];
  assign Data_20 = view[20];
  assign Data_21 = view[21];
  assign Data_22 = view[22];
  assign Data_23 = view[23];
  assign Data_24 = view[24];
  assign Data_25 = view[25];
  assign Data_26 = view[26];
  assign Data_27 = view[27];
  assign Data_28 = view[28];
  assign Data_29 = view[29];
  assign Data_30 = view[30];
  assign Data_31 = view[31];

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: randomized stimulus against an array model of the register bank, plus pinned literal checks.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteRegister = 5'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] d [32];

  logic [31:0] mdl [32];
  logic        chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = clk_en ? ~clk : 1'b0;

  register_bank dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Data_0(d[0]),   .Data_1(d[1]),   .Data_2(d[2]),   .Data_3(d[3]),
    .Data_4(d[4]),   .Data_5(d[5]),   .Data_6(d[6]),   .Data_7(d[7]),
    .Data_8(d[8]),   .Data_9(d[9]),   .Data_10(d[10]), .Data_11(d[11]),
    .Data_12(d[12]), .Data_13(d[13]), .Data_14(d[14]), .Data_15(d[15]),
    .Data_16(d[16]), .Data_17(d[17]), .Data_18(d[18]), .Data_19(d[19]),
    .Data_20(d[20]), .Data_21(d[21]), .Data_22(d[22]), .Data_23(d[23]),
    .Data_24(d[24]), .Data_25(d[25]), .Data_26(d[26]), .Data_27(d[27]),
    .Data_28(d[28]), .Data_29(d[29]), .Data_30(d[30]), .Data_31(d[31])
  );

  // Reference model: architectural register contents
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) mdl[k] <= 32'd0;
      mdl[28] <= 32'h1000_8000;
      mdl[29] <= 32'h7FFF_EFFC;
    end else if (RegWrite === 1'b1 && WriteRegister != 5'd0) begin
      mdl[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [31:0] expect_of(input int k);
    logic [31:0] v;
    v = (k == 0) ? 32'd0 : mdl[k];
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
    if (k != 0 && reset === 1'b0 && RegWrite === 1'b1 && WriteRegister === 5'(k)) v = WriteData;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 32; k++) check($sformatf("model_r%0d", k), d[k], expect_of(k));
    end
  end

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] dat);
    RegWrite = w; WriteRegister = a; WriteData = dat;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #20 reset = 1'b0;
    #1;
    for (int k = 0; k < 32; k++) begin
      if (k == 28)      check("reset_gp", d[k], 32'h1000_8000);
      else if (k == 29) check("reset_sp", d[k], 32'h7FFF_EFFC);
      else              check($sformatf("reset_r%0d", k), d[k], 32'd0);
    end
    clk_en = 1'b1;
    chk_en = 1'b1;

    cyc(1'b1, 5'd8, 32'hDEAD_BEEF);
    cyc(1'b0, 5'd8, 32'd0);
    check("write_r8", d[8], 32'hDEAD_BEEF);
    check("write_r7_untouched", d[7], 32'd0);

    cyc(1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc(1'b0, 5'd0, 32'd0);
    check("r0_immune", d[0], 32'd0);
    check("r0_gp_kept", d[28], 32'h1000_8000);

    for (int k = 1; k < 32; k++) cyc(1'b1, 5'(k), 32'(k) * 32'h0101_0101);
    cyc(1'b1, 5'd31, 32'h1234_5678);
    cyc(1'b0, 5'd0, 32'd0);
    for (int k = 1; k < 31; k++) check($sformatf("sweep_r%0d", k), d[k], 32'(k) * 32'h0101_0101);
    check("sweep_r30_lit", d[30], 32'h1E1E_1E1E);
    check("sweep_last_wins", d[31], 32'h1234_5678);

    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hCAFE_0005;
    #2;
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
    check("bypass_r5", d[5], 32'hCAFE_0005);
`else
    check("no_bypass_r5", d[5], 32'h0505_0505);
`endif
    @(posedge clk); #1;
    check("after_edge_r5", d[5], 32'hCAFE_0005);

    RegWrite = 1'b1; WriteRegister = 5'd29; WriteData = 32'd0;
    reset = 1'b1;
    #1;
    check("mid_reset_async", d[29], 32'h7FFF_EFFC);
    check("mid_reset_r5", d[5], 32'd0);
    @(posedge clk); #1;
    check("mid_reset_write_lost", d[29], 32'h7FFF_EFFC);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_write", d[29], 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        cyc(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        reset = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        cyc(1'b0, 5'bxxxxx, $urandom);
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom);
      end
    end
    RegWrite = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
